// File: rtl/div_seq_beh.sv
// div_seq_beh -- 8-bit sequential restoring divider.
// One quotient bit is produced per clock, MSB first, over eight RUN cycles.
// A zero divisor is detected in the first RUN cycle and short-circuits the
// operation to DONE with Q=0xFF, R=A and the error flag set.
// Optional feature: define DIV_SIGNED_EN for two's-complement operands.
// Operands are reduced to magnitudes at capture, the same unsigned core runs,
// and the signs are restored when the result is published. The default build
// has no sign-handling logic.
module div_seq_beh (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       busy,
    output logic       done,
    output logic       Z,
    output logic       O
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_n;

    logic [7:0]  a_r;       // dividend exactly as captured (returned as R on /0)
    logic [7:0]  b_r;       // divisor magnitude used by the core
    logic [7:0]  dvd_r;     // dividend magnitude, shifted out MSB first
    logic [8:0]  rem_r;     // partial remainder, one spare bit for the borrow
    logic [7:0]  quo_r;     // quotient bits shifted in LSB first
    logic [2:0]  cnt_r;     // RUN step counter

    logic [7:0]  q_r;
    logic [7:0]  r_r;
    logic        busy_r;
    logic        done_r;
    logic        z_r;
    logic        o_r;

    logic [9:0]  shifted_s;
    logic [9:0]  diff_s;
    logic        borrow_s;
    logic [8:0]  rem_n_s;
    logic [7:0]  res_q_s;
    logic [7:0]  res_r_s;
    logic        res_o_s;
    logic [7:0]  cap_a_s;
    logic [7:0]  cap_b_s;

`ifdef DIV_SIGNED_EN
    logic        sa_r;
    logic        sb_r;
`endif

    // Two's-complement negation of a byte.
    function automatic logic [7:0] neg8(input logic [7:0] v);
        neg8 = 8'd0 - v;
    endfunction

    // Magnitude of a two's-complement byte (0x80 maps to 0x80 as unsigned 128).
    function automatic logic [7:0] mag8(input logic [7:0] v);
        mag8 = v[7] ? neg8(v) : v;
    endfunction

    // Operand values presented to the core at capture time.
    always_comb begin
`ifdef DIV_SIGNED_EN
        cap_a_s = mag8(A);
        cap_b_s = mag8(B);
`else
        cap_a_s = A;
        cap_b_s = B;
`endif
    end

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted_s = {rem_r, dvd_r[7]};
        diff_s    = shifted_s - {2'b00, b_r};
        borrow_s  = diff_s[9];
        if (borrow_s) begin
            rem_n_s = shifted_s[8:0];
        end else begin
            rem_n_s = diff_s[8:0];
        end
    end

    // Final result selection, including divide-by-zero and sign restoration.
    always_comb begin
        res_q_s = quo_r;
        res_r_s = rem_r[7:0];
        res_o_s = 1'b0;
        if (b_r == 8'h00) begin
            res_q_s = 8'hFF;
            res_r_s = a_r;
            res_o_s = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            res_q_s = (sa_r ^ sb_r) ? neg8(quo_r) : quo_r;
            res_r_s = sa_r ? neg8(rem_r[7:0]) : rem_r[7:0];
            // -128 / -1 does not fit in a signed byte.
            res_o_s = sa_r && sb_r && (a_r == 8'h80) && (b_r == 8'h01);
`else
            res_q_s = quo_r;
            res_r_s = rem_r[7:0];
            res_o_s = 1'b0;
`endif
        end
    end

    // Next-state logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (b_r == 8'h00) begin
                    state_n = DONE;
                end else if (cnt_r == 3'd7) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Operand capture and the shift-subtract datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= 8'h00;
            b_r   <= 8'h00;
            dvd_r <= 8'h00;
            rem_r <= 9'h000;
            quo_r <= 8'h00;
            cnt_r <= 3'd0;
        end else if ((state_r == IDLE) && start) begin
            a_r   <= A;
            b_r   <= cap_b_s;
            dvd_r <= cap_a_s;
            rem_r <= 9'h000;
            quo_r <= 8'h00;
            cnt_r <= 3'd0;
        end else if ((state_r == RUN) && (b_r != 8'h00)) begin
            dvd_r <= {dvd_r[6:0], 1'b0};
            rem_r <= rem_n_s;
            quo_r <= {quo_r[6:0], ~borrow_s};
            cnt_r <= cnt_r + 3'd1;
        end else begin
            a_r   <= a_r;
            b_r   <= b_r;
            dvd_r <= dvd_r;
            rem_r <= rem_r;
            quo_r <= quo_r;
            cnt_r <= cnt_r;
        end
    end

`ifdef DIV_SIGNED_EN
    // Operand signs, captured alongside the magnitudes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_r <= 1'b0;
            sb_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            sa_r <= A[7];
            sb_r <= B[7];
        end else begin
            sa_r <= sa_r;
            sb_r <= sb_r;
        end
    end
`endif

    // Registered outputs: results are published on the edge that leaves DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= 8'h00;
            r_r    <= 8'h00;
            z_r    <= 1'b0;
            o_r    <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_n == RUN);
            if (state_r == DONE) begin
                q_r    <= res_q_s;
                r_r    <= res_r_s;
                z_r    <= (res_q_s == 8'h00);
                o_r    <= res_o_s;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end
    end

    assign Q    = q_r;
    assign R    = r_r;
    assign Z    = z_r;
    assign O    = o_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_div_seq_beh.sv
// Directed, table-driven bench for div_seq_beh plus hand-written sequences
// for back-to-back starts, ignored starts, operand changes and mid-run reset.
module tb_div_seq_beh;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Q;
    logic [7:0] R;
    logic       busy;
    logic       done;
    logic       Z;
    logic       O;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        logic       o;
        int         lat;
        int         bc;
    } vec_t;

    vec_t vt[9];

    div_seq_beh dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .Z     (Z),
        .O     (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one division and check latency, busy length, result and pulse width.
    task automatic run_op(input vec_t v);
        int n;
        int bcnt;
        logic moved;
        logic [7:0] q_prev;
        @(negedge clk);
        A = v.a;
        B = v.b;
        start = 1'b1;
        q_prev = Q;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        moved = 1'b0;
        bcnt = busy ? 1 : 0;
        while (!done && n < 30) begin
            if (Q !== q_prev) moved = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (busy) bcnt++;
        end
        chk($sformatf("latency %h/%h", v.a, v.b), n, v.lat);
        chk($sformatf("busy_len %h/%h", v.a, v.b), bcnt, v.bc);
        chk($sformatf("q_hold %h/%h", v.a, v.b), moved, 1'b0);
        chk($sformatf("Q %h/%h", v.a, v.b), Q, v.q);
        chk($sformatf("R %h/%h", v.a, v.b), R, v.r);
        chk($sformatf("Z %h/%h", v.a, v.b), Z, v.z);
        chk($sformatf("O %h/%h", v.a, v.b), O, v.o);
        @(posedge clk);
        #1;
        chk($sformatf("done_pulse %h/%h", v.a, v.b), done, 1'b0);
    endtask

    initial begin
        int n;
        int dcnt;
        int d1;
        int d2;
        logic [7:0] cq;
        logic [7:0] cr;
        vec_t v;

        vt[0] = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9, 8};
        vt[1] = '{8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b0, 1'b1, 2, 1};
        vt[2] = '{8'h03, 8'h09, 8'h00, 8'h03, 1'b1, 1'b0, 9, 8};
        vt[3] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9, 8};
        vt[4] = '{8'h10, 8'h04, 8'h04, 8'h00, 1'b0, 1'b0, 9, 8};
        vt[5] = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 9, 8};
        vt[6] = '{8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 9, 8};
`ifdef DIV_SIGNED_EN
        vt[7] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 9, 8};
        vt[8] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 9, 8};
`else
        vt[7] = '{8'hC8, 8'h0D, 8'h0F, 8'h05, 1'b0, 1'b0, 9, 8};
        vt[8] = '{8'h80, 8'h00, 8'hFF, 8'h80, 1'b0, 1'b1, 2, 1};
`endif

        rst = 1'b1;
        start = 1'b0;
        A = 8'h00;
        B = 8'h00;
        #12;
        chk("reset Q", Q, 8'h00);
        chk("reset R", R, 8'h00);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset Z", Z, 1'b0);
        chk("reset O", O, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vt[i]);
        end

        // Start pulsed mid-run with new operands: ignored, one done only.
        @(negedge clk);
        A = 8'h64;
        B = 8'h07;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcnt = 0;
        cq = 8'h00;
        cr = 8'h00;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                start = 1'b1;
                A = 8'h0F;
                B = 8'h05;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                dcnt++;
                cq = Q;
                cr = R;
            end
        end
        chk("ignored_start done_count", dcnt, 1);
        chk("ignored_start Q", cq, 8'h0E);
        chk("ignored_start R", cr, 8'h02);

        // start held high: back-to-back launches every 10 cycles.
        @(negedge clk);
        A = 8'h64;
        B = 8'h07;
        start = 1'b1;
        @(posedge clk);
        #1;
        A = 8'h0F;
        B = 8'h05;
        n = 0;
        d1 = -1;
        d2 = -1;
        while (d2 < 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    chk("b2b first Q", Q, 8'h0E);
                    chk("b2b first R", R, 8'h02);
                end else begin
                    d2 = n;
                    chk("b2b second Q", Q, 8'h03);
                    chk("b2b second R", R, 8'h00);
                end
            end
        end
        start = 1'b0;
        chk("b2b first latency", d1, 9);
        chk("b2b second latency", d2, 19);
        repeat (3) @(posedge clk);

        // Reset asserted in RUN cycle 4 discards the operation.
        @(negedge clk);
        A = 8'h64;
        B = 8'h07;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst Q", Q, 8'h00);
        chk("midrst R", R, 8'h00);
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst Z", Z, 1'b0);
        chk("midrst O", O, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        chk("midrst no_activity", dcnt, 0);
        v = '{8'h10, 8'h04, 8'h04, 8'h00, 1'b0, 1'b0, 9, 8};
        run_op(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_seq_beh.md
DIV_SEQ_BEH -- requirements
Module: div_seq_beh

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port A, input, 8 bits: dividend; captured on the accepted start.
REQ-005 SHALL have port B, input, 8 bits: divisor; captured on the accepted start.
REQ-006 SHALL have port Q, output, 8 bits: quotient, registered.
REQ-007 SHALL have port R, output, 8 bits: remainder, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when Q/R/Z/O become valid.
REQ-010 SHALL have port Z, output, 1 bit: zero flag, high when the result Q equals 0x00.
REQ-011 SHALL have port O, output, 1 bit: error flag, high on divide-by-zero (and on signed overflow per REQ-027).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 SHALL latch A and B, assert busy on the next edge, and enter RUN; start=0 SHALL hold IDLE.
REQ-014 SHALL use a restoring shift-subtract algorithm, one quotient bit per cycle, MSB first, over a 9-bit partial remainder.
REQ-015 The 9-bit partial remainder SHALL prevent loss of the borrow on every compare.
REQ-016 RUN SHALL last exactly 8 cycles, after which the FSM enters DONE.
REQ-017 The cycle after an accepted start SHALL be RUN cycle 1; done SHALL assert 9 cycles after the start edge.
REQ-018 In DONE, Q/R/Z/O SHALL update, done=1 and busy=0 for one cycle, then the FSM SHALL return to IDLE.
REQ-019 Q, R, Z and O SHALL hold their last values until the next DONE; they SHALL not change during RUN.
REQ-020 When B=0x00 is captured, the block SHALL skip RUN and enter DONE on the next cycle with Q=0xFF, R=A, O=1 and Z=0.
REQ-021 Otherwise O SHALL be 0.
REQ-022 start asserted while busy=1 or in DONE SHALL be ignored, with no effect on the operation in progress.
REQ-023 start held high continuously SHALL launch a new division from each IDLE visit, one every 10 cycles (back-to-back).
REQ-024 Changes on A or B after capture SHALL not affect the result.

Reset
REQ-025 rst=1 SHALL, asynchronously and at any state including mid-RUN, force IDLE with Q=0x00, R=0x00, busy=0, done=0, Z=0, O=0, and clear internal counters and registers.
REQ-026 Any operation interrupted by reset SHALL be discarded, with no done pulse; after rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-027 Macro DIV_SIGNED_EN defined SHALL treat A, B, Q and R as two's complement.
- Operands are converted to magnitudes, the same 8-cycle core is used, then signs are applied.
- Q truncates toward zero; R takes the sign of A.
- A=0x80 with B=0xFF SHALL give Q=0x80, R=0x00, O=1.
- Divide-by-zero gives Q=0xFF, R=A, O=1.
- Latency is unchanged.
REQ-028 DIV_SIGNED_EN undefined SHALL give unsigned operation only, with no sign-handling logic present.

Verification
REQ-029 Basic unsigned case: A=0x64 (100), B=0x07, start one cycle -> done 9 cycles later with Q=0x0E, R=0x02, Z=0, O=0; busy high for 8 cycles.
REQ-030 Divide-by-zero: A=0x2A, B=0x00 -> done 2 cycles after start with Q=0xFF, R=0x2A, O=1, Z=0.
REQ-031 Zero quotient and full range:
- A=0x03, B=0x09 -> Q=0x00, R=0x03, Z=1.
- A=0xFF, B=0x01 -> Q=0xFF, R=0x00.
REQ-032 Start and operand robustness: start pulsed during RUN and A/B changed mid-run -> first result unaffected, no extra done.
REQ-033 Reset mid-operation: rst asserted at RUN cycle 4 -> immediately IDLE with all outputs 0 and no done; a subsequent A=0x10, B=0x04 -> Q=0x04, R=0x00.
REQ-034 Signed mode (DIV_SIGNED_EN defined):
- A=0xF9 (-7), B=0x02 -> Q=0xFD (-3), R=0xFF (-1).
- A=0x80, B=0xFF -> O=1, Q=0x80.
